// File: rtl/rv_iopmp_walker.sv
// rv_iopmp_walker
//   Sequential IOPMP rule checker. Accepts one transaction at a time and walks
//   the entry table one entry per cycle in index order. The first entry that
//   matches and is owned by an enabled memory domain decides the response.
//   Entries and mdcfg are read through a combinational port: entry_i must
//   present the entry addressed by entry_idx_o in the same cycle.
//
// Optional feature (macro RV_IOPMP_ERR_CAPTURE_EN):
//   Defined   -> adds the error capture ports err_* and their capture logic.
//   Undefined -> ports and logic absent.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   iopmp_en_i             global enable, sampled at accept (0 = allow all)
//   req_*                  request channel (valid/ready handshake)
//     req_access_i         one-hot: 3'b001 READ, 3'b010 WRITE, 3'b100 EXECUTION
//     req_md_en_i          srcmd MD enable bits for this requester
//   entry_idx_o / entry_i  table read port
//     entry_i[0]     r
//     entry_i[1]     w
//     entry_i[2]     x
//     entry_i[4:3]   a  (0 OFF, 1 TOR, 2 NA4, 3 NAPOT)
//     entry_i[36:5]  addr   (byte address bits [33:2])
//     entry_i[68:37] addrh  (byte address bits [65:34])
//   mdcfg_t_i              16-bit top index per MD, MD m at [m*16 +: 16]
//   resp_*                 response channel, held until resp_ready_i
//   err_*                  first-deny capture (optional feature only)
//
// States:
//   IDLE | ready for a request
//   WALK | evaluating entry entry_idx_o
//   RESP | response presented, waiting for resp_ready_i

module rv_iopmp_walker #(
  parameter  int unsigned NumEntries = 16,
  parameter  int unsigned NumMD      = 4,
  parameter  int unsigned ReqIdWidth = 8,
  localparam int unsigned EW         = $clog2(NumEntries),
  localparam int unsigned EntryW     = 69
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iopmp_en_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [63:0]           req_addr_i,
  input  logic [2:0]            req_access_i,
  input  logic [ReqIdWidth-1:0] req_id_i,
  input  logic [NumMD-1:0]      req_md_en_i,
  output logic [EW-1:0]         entry_idx_o,
  input  logic [EntryW-1:0]     entry_i,
  input  logic [NumMD*16-1:0]   mdcfg_t_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  resp_allow_o,
  output logic [2:0]            resp_etype_o,
  output logic [EW-1:0]         resp_entry_o,
  output logic                  resp_hit_o
`ifdef RV_IOPMP_ERR_CAPTURE_EN
  ,
  input  logic                  err_clear_i,
  output logic                  err_valid_o,
  output logic [2:0]            err_etype_o,
  output logic [1:0]            err_ttype_o,
  output logic [ReqIdWidth-1:0] err_id_o,
  output logic [63:0]           err_addr_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [EW-1:0] LastIdx = EW'(NumEntries - 1);

  state_t           state_q;
  logic [63:0]      prev_q;
  logic [63:0]      req_addr_q;
  logic [2:0]       req_access_q;
  logic [NumMD-1:0] req_md_en_q;

  // Entry decode
  logic [63:0] ea;
  logic [1:0]  cfg_a;
  logic        cfg_r, cfg_w, cfg_x;

  assign ea    = entry_i[68:5];
  assign cfg_a = entry_i[4:3];
  assign cfg_x = entry_i[2];
  assign cfg_w = entry_i[1];
  assign cfg_r = entry_i[0];

  // Request address in entry-address units (byte address bits [63:2]).
  logic [63:0] addr_w;
  assign addr_w = {2'b00, req_addr_q[63:2]};

  // Bits above the lowest zero of EA. EA ^ (EA+1) sets exactly the trailing
  // ones plus that first zero, so the complement keeps the compared bits.
  // All-ones EA yields a zero mask, i.e. matches everything.
  logic [63:0] napot_mask;
  assign napot_mask = ~(ea ^ (ea + 64'd1));

  logic addr_match;
  always_comb begin
    addr_match = 1'b0;
    case (cfg_a)
      2'b01:   addr_match = (prev_q <= addr_w) && (addr_w < ea);
      2'b10:   addr_match = (addr_w == ea);
      2'b11:   addr_match = ((addr_w ^ ea) & napot_mask) == 64'd0;
      default: addr_match = 1'b0;
    endcase
  end

  // MD m owns [t(m-1), t(m)); indices at or beyond the last top are unowned.
  logic        md_eligible;
  logic [15:0] md_lo, md_top, idx_ext;
  always_comb begin
    md_eligible = 1'b0;
    md_lo       = 16'd0;
    md_top      = 16'd0;
    idx_ext     = 16'(entry_idx_o);
    for (int m = 0; m < NumMD; m++) begin
      md_top = mdcfg_t_i[m*16 +: 16];
      if ((idx_ext >= md_lo) && (idx_ext < md_top)) begin
        md_eligible = md_eligible | req_md_en_q[m];
      end
      md_lo = md_top;
    end
  end

  logic perm_ok;
  assign perm_ok = |(req_access_q & {cfg_x, cfg_w, cfg_r});

  // Deny code by access type; doubles as the captured transaction type.
  logic [2:0] deny_etype;
  always_comb begin
    deny_etype = 3'd1;
    if (req_access_q[2])      deny_etype = 3'd3;
    else if (req_access_q[1]) deny_etype = 3'd2;
    else                      deny_etype = 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_ready_o  <= 1'b1;
      entry_idx_o  <= '0;
      prev_q       <= 64'd0;
      req_addr_q   <= 64'd0;
      req_access_q <= 3'd0;
      req_md_en_q  <= '0;
      resp_valid_o <= 1'b0;
      resp_allow_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_etype_o <= 3'd0;
      resp_entry_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o  <= 1'b0;
            req_addr_q   <= req_addr_i;
            req_access_q <= req_access_i;
            req_md_en_q  <= req_md_en_i;
            if (!iopmp_en_i) begin
              state_q      <= RESP;
              resp_valid_o <= 1'b1;
              resp_allow_o <= 1'b1;
              resp_hit_o   <= 1'b0;
              resp_etype_o <= 3'd0;
              resp_entry_o <= '0;
            end else begin
              state_q     <= WALK;
              entry_idx_o <= '0;
              prev_q      <= 64'd0;
            end
          end
        end
        WALK: begin
          // TOR lower bound is always the previous entry, eligible or not.
          prev_q <= ea;
          if (md_eligible && addr_match) begin
            state_q      <= RESP;
            resp_valid_o <= 1'b1;
            resp_hit_o   <= 1'b1;
            resp_entry_o <= entry_idx_o;
            resp_allow_o <= perm_ok;
            resp_etype_o <= perm_ok ? 3'd0 : deny_etype;
            entry_idx_o  <= '0;
          end else if (entry_idx_o == LastIdx) begin
            state_q      <= RESP;
            resp_valid_o <= 1'b1;
            resp_hit_o   <= 1'b0;
            resp_entry_o <= '0;
            resp_allow_o <= 1'b0;
            resp_etype_o <= 3'd4;
            entry_idx_o  <= '0;
          end else begin
            entry_idx_o <= entry_idx_o + EW'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q      <= IDLE;
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_o <= 1'b1;
          entry_idx_o <= '0;
        end
      endcase
    end
  end

`ifdef RV_IOPMP_ERR_CAPTURE_EN
  logic [ReqIdWidth-1:0] req_id_q;
  logic                  deny_hs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_id_q <= '0;
    end else if ((state_q == IDLE) && req_valid_i) begin
      req_id_q <= req_id_i;
    end
  end

  assign deny_hs = resp_valid_o && resp_ready_i && !resp_allow_o;

  // A clear in the same cycle as a deny handshake still captures the deny.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_etype_o <= 3'd0;
      err_ttype_o <= 2'd0;
      err_id_o    <= '0;
      err_addr_o  <= 64'd0;
    end else if (deny_hs && (!err_valid_o || err_clear_i)) begin
      err_valid_o <= 1'b1;
      err_etype_o <= resp_etype_o;
      err_ttype_o <= deny_etype[1:0];
      err_id_o    <= req_id_q;
      err_addr_o  <= req_addr_q;
    end else if (err_clear_i) begin
      err_valid_o <= 1'b0;
    end
  end
`else
  // Requester ID and the sub-word address bits only feed error capture.
  logic unused_capture_inputs;
  assign unused_capture_inputs = ^{req_id_i, req_addr_q[1:0]};
`endif

endmodule

// File: tb/tb_rv_iopmp_walker.sv
module tb_rv_iopmp_walker;
  localparam int N   = 16;
  localparam int NMD = 4;
  localparam int IDW = 8;
  localparam int EW  = 4;

  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [2:0] ACC_X = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i;
  logic            iopmp_en_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [63:0]     req_addr_i;
  logic [2:0]      req_access_i;
  logic [IDW-1:0]  req_id_i;
  logic [NMD-1:0]  req_md_en_i;
  logic [EW-1:0]   entry_idx_o;
  logic [68:0]     entry_i;
  logic [NMD*16-1:0] mdcfg_t_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic            resp_allow_o;
  logic [2:0]      resp_etype_o;
  logic [EW-1:0]   resp_entry_o;
  logic            resp_hit_o;
`ifdef RV_IOPMP_ERR_CAPTURE_EN
  logic            err_clear_i;
  logic            err_valid_o;
  logic [2:0]      err_etype_o;
  logic [1:0]      err_ttype_o;
  logic [IDW-1:0]  err_id_o;
  logic [63:0]     err_addr_o;
`endif

  rv_iopmp_walker dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .iopmp_en_i   (iopmp_en_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_access_i (req_access_i),
    .req_id_i     (req_id_i),
    .req_md_en_i  (req_md_en_i),
    .entry_idx_o  (entry_idx_o),
    .entry_i      (entry_i),
    .mdcfg_t_i    (mdcfg_t_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_allow_o (resp_allow_o),
    .resp_etype_o (resp_etype_o),
    .resp_entry_o (resp_entry_o),
    .resp_hit_o   (resp_hit_o)
`ifdef RV_IOPMP_ERR_CAPTURE_EN
    ,
    .err_clear_i  (err_clear_i),
    .err_valid_o  (err_valid_o),
    .err_etype_o  (err_etype_o),
    .err_ttype_o  (err_ttype_o),
    .err_id_o     (err_id_o),
    .err_addr_o   (err_addr_o)
`endif
  );

  // Entry table and MD tops as seen by the register file.
  logic [63:0] tb_ea [N];
  logic [1:0]  tb_a  [N];
  logic        tb_r  [N];
  logic        tb_w  [N];
  logic        tb_x  [N];
  logic [15:0] tb_t  [NMD];

  always_comb begin
    entry_i = {tb_ea[entry_idx_o], tb_a[entry_idx_o], tb_x[entry_idx_o],
               tb_w[entry_idx_o], tb_r[entry_idx_o]};
  end

  always_comb begin
    mdcfg_t_i = '0;
    for (int m = 0; m < NMD; m++) mdcfg_t_i[m*16 +: 16] = tb_t[m];
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          allow;
    logic          hit;
    logic [2:0]    etype;
    logic [EW-1:0] entry;
    int            lat;
  } exp_t;

  // Reference: scan the table from index 0; first eligible match decides.
  function automatic exp_t model(input logic [63:0] addr, input logic [2:0] acc,
                                 input logic [NMD-1:0] md, input logic en);
    exp_t e;
    logic [63:0] a_w, prev;
    int lo, k;
    bit elig, m_ok, perm;
    e = '0;
    if (!en) begin
      e.allow = 1'b1;
      e.lat   = 1;
      return e;
    end
    a_w = addr >> 2;
    for (int i = 0; i < N; i++) begin
      prev = (i == 0) ? 64'd0 : tb_ea[i-1];
      elig = 0;
      lo   = 0;
      for (int m = 0; m < NMD; m++) begin
        if (i >= lo && i < int'(tb_t[m])) elig = elig | md[m];
        lo = int'(tb_t[m]);
      end
      case (tb_a[i])
        2'd1: m_ok = (prev <= a_w) && (a_w < tb_ea[i]);
        2'd2: m_ok = (a_w == tb_ea[i]);
        2'd3: begin
          k = 0;
          while (k < 64 && tb_ea[i][k]) k++;
          m_ok = (k >= 63) || ((a_w >> (k + 1)) == (tb_ea[i] >> (k + 1)));
        end
        default: m_ok = 0;
      endcase
      if (elig && m_ok) begin
        e.hit   = 1'b1;
        e.entry = EW'(i);
        e.lat   = i + 2;
        perm = (acc == ACC_R) ? tb_r[i] : (acc == ACC_W) ? tb_w[i] : tb_x[i];
        e.allow = perm;
        e.etype = perm ? 3'd0 : (acc == ACC_R) ? 3'd1 : (acc == ACC_W) ? 3'd2 : 3'd3;
        return e;
      end
    end
    e.etype = 3'd4;
    e.lat   = N + 1;
    return e;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      tb_ea[i] = 64'd0; tb_a[i] = 2'd0; tb_r[i] = 0; tb_w[i] = 0; tb_x[i] = 0;
    end
    for (int m = 0; m < NMD; m++) tb_t[m] = 16'd16;
  endtask

  // One full transaction: accept, walk, optional backpressure, consume.
  task automatic do_req(input string nm, input logic [63:0] addr, input logic [2:0] acc,
                        input logic [NMD-1:0] md, input logic en, input logic [IDW-1:0] id,
                        input int hold, input bit flip_en);
    exp_t e;
    int lat;
    e = model(addr, acc, md, en);
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle: got %b want 1", nm, req_ready_o);
    end
    req_valid_i = 1'b1; req_addr_i = addr; req_access_i = acc;
    req_md_en_i = md; req_id_i = id; iopmp_en_i = en;
    @(posedge clk); #1;
    req_valid_i  = 1'b0;
    req_addr_i   = {$urandom, $urandom};
    req_access_i = ACC_X;
    req_md_en_i  = NMD'($urandom);
    req_id_i     = IDW'($urandom);
    if (flip_en) iopmp_en_i = ~en;
    lat = 1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++; $display("FAIL %s ready_busy: got %b want 0", nm, req_ready_o);
    end
    while (resp_valid_o !== 1'b1 && lat < N + 10) begin
      checks++;
      if (entry_idx_o !== EW'(lat - 1)) begin
        errors++; $display("FAIL %s walk_idx: got %0d want %0d", nm, entry_idx_o, lat - 1);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (resp_valid_o !== 1'b1 || lat != e.lat) begin
      errors++; $display("FAIL %s latency: got %0d (valid %b) want %0d", nm, lat, resp_valid_o, e.lat);
    end
    checks++;
    if (resp_allow_o !== e.allow || resp_hit_o !== e.hit) begin
      errors++; $display("FAIL %s allow_hit: got %b/%b want %b/%b", nm, resp_allow_o, resp_hit_o, e.allow, e.hit);
    end
    checks++;
    if (resp_etype_o !== e.etype) begin
      errors++; $display("FAIL %s etype: got %0d want %0d", nm, resp_etype_o, e.etype);
    end
    checks++;
    if (resp_entry_o !== e.entry || entry_idx_o !== '0) begin
      errors++; $display("FAIL %s entry: got %0d idx %0d want %0d idx 0", nm, resp_entry_o, entry_idx_o, e.entry);
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({resp_valid_o, req_ready_o, resp_allow_o, resp_hit_o, resp_etype_o, resp_entry_o} !==
          {1'b1, 1'b0, e.allow, e.hit, e.etype, e.entry}) begin
        errors++;
        $display("FAIL %s hold%0d: got v%b rdy%b a%b h%b e%0d n%0d", nm, c, resp_valid_o,
                 req_ready_o, resp_allow_o, resp_hit_o, resp_etype_o, resp_entry_o);
      end
    end
    @(negedge clk);
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s after_consume: got valid %b ready %b want 0 1", nm, resp_valid_o, req_ready_o);
    end
    iopmp_en_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready_o, resp_valid_o, resp_allow_o, resp_hit_o, resp_etype_o, resp_entry_o, entry_idx_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_values: got rdy%b v%b a%b h%b e%0d n%0d idx%0d want 1 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_allow_o, resp_hit_o, resp_etype_o, resp_entry_o, entry_idx_o);
    end
`ifdef RV_IOPMP_ERR_CAPTURE_EN
    checks++;
    if ({err_valid_o, err_etype_o, err_ttype_o, err_id_o, err_addr_o} !== '0) begin
      errors++; $display("FAIL reset_err: got v%b e%0d t%0d id%0h a%0h want zeros",
                         err_valid_o, err_etype_o, err_ttype_o, err_id_o, err_addr_o);
    end
`endif
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_disabled();
    clear_table();
    tb_a[0] = 2'd3; tb_ea[0] = '1;
    do_req("disabled", 64'h8000_0000, ACC_R, 4'b0000, 1'b0, 8'h11, 0, 1'b0);
  endtask

  task automatic test_na4();
    clear_table();
    tb_t[0] = 16'd4; tb_t[1] = 16'd8; tb_t[2] = 16'd12; tb_t[3] = 16'd16;
    tb_a[3] = 2'd2; tb_ea[3] = 64'h2000_0000 >> 2; tb_w[3] = 1'b1;
    do_req("na4_write_allow", 64'h2000_0000, ACC_W, 4'b0001, 1'b1, 8'h22, 0, 1'b0);
    tb_w[3] = 1'b0; tb_r[3] = 1'b1;
    do_req("na4_write_deny", 64'h2000_0000, ACC_W, 4'b0001, 1'b1, 8'h23, 0, 1'b0);
    do_req("na4_off_by_one", 64'h2000_0004, ACC_R, 4'b0001, 1'b1, 8'h24, 0, 1'b0);
  endtask

  task automatic test_tor_md();
    clear_table();
    tb_t[0] = 16'd4; tb_t[1] = 16'd8; tb_t[2] = 16'd12; tb_t[3] = 16'd16;
    tb_ea[0] = 64'h1000 >> 2;
    tb_a[1] = 2'd1; tb_ea[1] = 64'h2000 >> 2; tb_r[1] = 1'b1;
    do_req("tor_hit", 64'h1800, ACC_R, 4'b0001, 1'b1, 8'h31, 0, 1'b0);
    do_req("tor_low_edge", 64'h0FFC, ACC_R, 4'b0001, 1'b1, 8'h32, 0, 1'b0);
    do_req("tor_high_edge", 64'h2000, ACC_R, 4'b0001, 1'b1, 8'h33, 0, 1'b0);
    tb_t[0] = 16'd1;
    do_req("tor_md_gated", 64'h1800, ACC_R, 4'b0001, 1'b1, 8'h34, 0, 1'b0);
    tb_t[0] = 16'd1; tb_t[1] = 16'd1; tb_t[2] = 16'd1; tb_t[3] = 16'd1;
    do_req("tor_unowned", 64'h1800, ACC_R, 4'b1111, 1'b1, 8'h35, 0, 1'b0);
  endtask

  task automatic test_napot_priority();
    clear_table();
    tb_a[2] = 2'd3; tb_ea[2] = (64'h4000 + 64'h7FF) >> 2; tb_r[2] = 1'b0; tb_w[2] = 1'b1;
    tb_a[5] = 2'd3; tb_ea[5] = (64'h0 + 64'h7FFF) >> 2;   tb_r[5] = 1'b1;
    do_req("napot_priority", 64'h4010, ACC_R, 4'b0001, 1'b1, 8'h41, 0, 1'b0);
    do_req("napot_outer", 64'h5010, ACC_R, 4'b0001, 1'b1, 8'h42, 0, 1'b0);
    tb_a[15] = 2'd3; tb_ea[15] = '1; tb_x[15] = 1'b1;
    do_req("napot_all_ones", 64'hFFFF_0000_1234_5670, ACC_X, 4'b1000, 1'b1, 8'h43, 0, 1'b0);
  endtask

  task automatic test_backpressure_reset();
    bit seen;
    clear_table();
    tb_a[6] = 2'd2; tb_ea[6] = 64'h300 >> 2; tb_x[6] = 1'b1;
    do_req("backpressure", 64'h300, ACC_X, 4'b0010, 1'b1, 8'h51, 10, 1'b1);
    clear_table();
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 64'h700; req_access_i = ACC_R;
    req_md_en_i = 4'b1111; iopmp_en_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready_o, resp_valid_o, resp_allow_o, resp_hit_o, resp_etype_o, resp_entry_o, entry_idx_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid_walk: got rdy%b v%b a%b h%b e%0d n%0d idx%0d want 1 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_allow_o, resp_hit_o, resp_etype_o, resp_entry_o, entry_idx_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    seen = 0;
    for (int c = 0; c < N + 5; c++) begin
      @(posedge clk); #1;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_no_response: got a response or busy after abort, want idle");
    end
  endtask

  task automatic test_random();
    logic [2:0] acc;
    logic [63:0] base;
    int k;
    for (int t = 0; t < 60; t++) begin
      if (t % 10 == 0) begin
        for (int i = 0; i < N; i++) begin
          tb_a[i] = 2'($urandom_range(0, 3));
          tb_r[i] = 1'($urandom); tb_w[i] = 1'($urandom); tb_x[i] = 1'($urandom);
          if (tb_a[i] == 2'd3) begin
            k = $urandom_range(0, 6);
            base = 64'($urandom_range(0, 1023));
            tb_ea[i] = ((base >> (k + 1)) << (k + 1)) | ((64'd1 << k) - 64'd1);
            if ($urandom_range(0, 15) == 0) tb_ea[i] = '1;
          end else begin
            tb_ea[i] = 64'($urandom_range(0, 1023));
          end
        end
        tb_t[0] = 16'($urandom_range(0, 8));
        for (int m = 1; m < NMD; m++)
          tb_t[m] = 16'((int'(tb_t[m-1]) + $urandom_range(0, 6) > 16) ? 16 : int'(tb_t[m-1]) + $urandom_range(0, 6));
      end
      case ($urandom_range(0, 2))
        0: acc = ACC_R;
        1: acc = ACC_W;
        default: acc = ACC_X;
      endcase
      do_req("random", 64'($urandom_range(0, 4095)), acc, NMD'($urandom), ($urandom_range(0, 7) != 0),
             IDW'($urandom), $urandom_range(0, 2), 1'($urandom));
    end
  endtask

`ifdef RV_IOPMP_ERR_CAPTURE_EN
  task automatic test_err_capture();
    clear_table();
    tb_ea[0] = 64'h1000 >> 2;
    tb_a[1] = 2'd1; tb_ea[1] = 64'h2000 >> 2;
    tb_a[3] = 2'd2; tb_ea[3] = 64'h2000_0000 >> 2; tb_r[3] = 1'b1;
    // Clear any capture left over from earlier scenarios.
    @(negedge clk); err_clear_i = 1'b1;
    @(negedge clk); err_clear_i = 1'b0;
    do_req("err_first", 64'h2000_0000, ACC_W, 4'b0001, 1'b1, 8'h5A, 0, 1'b0);
    do_req("err_second", 64'h1800, ACC_R, 4'b0001, 1'b1, 8'hA5, 0, 1'b0);
    checks++;
    if ({err_valid_o, err_etype_o, err_ttype_o, err_id_o, err_addr_o} !==
        {1'b1, 3'd2, 2'd2, 8'h5A, 64'h2000_0000}) begin
      errors++; $display("FAIL err_hold_first: got v%b e%0d t%0d id%0h a%0h want 1 2 2 5a 20000000",
                         err_valid_o, err_etype_o, err_ttype_o, err_id_o, err_addr_o);
    end
    err_clear_i = 1'b1;
    do_req("err_clear_same_cycle", 64'h1800, ACC_R, 4'b0001, 1'b1, 8'h77, 0, 1'b0);
    err_clear_i = 1'b0;
    checks++;
    if ({err_valid_o, err_etype_o, err_ttype_o, err_id_o, err_addr_o} !==
        {1'b1, 3'd1, 2'd1, 8'h77, 64'h1800}) begin
      errors++; $display("FAIL err_recapture: got v%b e%0d t%0d id%0h a%0h want 1 1 1 77 1800",
                         err_valid_o, err_etype_o, err_ttype_o, err_id_o, err_addr_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; iopmp_en_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0;
    req_access_i = ACC_R; req_id_i = '0; req_md_en_i = '0; resp_ready_i = 1'b0;
`ifdef RV_IOPMP_ERR_CAPTURE_EN
    err_clear_i = 1'b0;
`endif
    clear_table();
    test_reset();
    test_disabled();
    test_na4();
    test_tor_md();
    test_napot_priority();
    test_backpressure_reset();
    test_random();
`ifdef RV_IOPMP_ERR_CAPTURE_EN
    test_err_capture();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
